// File: rtl/disparity_wta.sv
// Winner-take-all disparity selector: tracks min / second-min cost over one pixel's
// disparity sweep and presents the winner through a registered valid/ready output.
module disparity_wta #(
  parameter  int COST_W      = 10,
  parameter  int DISP_RANGE  = 64,
  parameter  int UNIQ_MARGIN = 0,
  localparam int DISP_W      = (DISP_RANGE > 1) ? $clog2(DISP_RANGE) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [COST_W-1:0] in_cost,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DISP_W-1:0] out_disp,
  output logic [COST_W-1:0] out_cost,
  output logic              out_ambig,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam logic [DISP_W-1:0] LAST_D = DISP_W'(DISP_RANGE - 1);

  logic [DISP_W-1:0] d_p0;
  logic [COST_W-1:0] min_cost_p0;
  logic [COST_W-1:0] second_cost_p0;
  logic [DISP_W-1:0] min_idx_p0;

  logic [COST_W-1:0] nxt_min;
  logic [COST_W-1:0] nxt_second;
  logic [DISP_W-1:0] nxt_idx;

  logic [DISP_W-1:0] disp_p1;
  logic [COST_W-1:0] cost_p1;
  logic              ambig_p1;
  logic              vld_p1;

  logic first_beat;
  logic last_beat;
  logic accept;
  logic load;

  // Unsigned gap between runner-up and winner, one bit wider so it cannot wrap.
  function automatic logic ambig_of(input logic [COST_W-1:0] lo,
                                    input logic [COST_W-1:0] hi);
    logic [COST_W:0] diff;
    diff = {1'b0, hi} - {1'b0, lo};
    return (UNIQ_MARGIN != 0) && (32'(diff) < 32'(UNIQ_MARGIN));
  endfunction

  assign first_beat = (d_p0 == '0);
  assign last_beat  = (d_p0 == LAST_D);
  // Only the final beat of a pixel needs a free output slot.
  assign in_ready   = !(vld_p1 && !out_ready && last_beat);
  assign accept     = in_valid && in_ready;
  assign load       = accept && last_beat;

  always_comb begin
    nxt_min    = min_cost_p0;
    nxt_second = second_cost_p0;
    nxt_idx    = min_idx_p0;
    if (first_beat) begin
      nxt_min    = in_cost;
      nxt_second = '1;
      nxt_idx    = '0;
    end else if (in_cost < min_cost_p0) begin
      nxt_second = min_cost_p0;
      nxt_min    = in_cost;
      nxt_idx    = d_p0;
    end else if (in_cost < second_cost_p0) begin
      nxt_second = in_cost;
    end
  end

  // Stage p0: disparity counter and running trackers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_p0           <= '0;
      min_cost_p0    <= '0;
      second_cost_p0 <= '0;
      min_idx_p0     <= '0;
    end else if (accept) begin
      d_p0           <= last_beat ? '0 : d_p0 + DISP_W'(1);
      min_cost_p0    <= nxt_min;
      second_cost_p0 <= nxt_second;
      min_idx_p0     <= nxt_idx;
    end
  end

  // Stage p1: result register, fields only change on a load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      disp_p1  <= '0;
      cost_p1  <= '0;
      ambig_p1 <= 1'b0;
    end else if (load) begin
      vld_p1   <= 1'b1;
      disp_p1  <= nxt_idx;
      cost_p1  <= nxt_min;
      ambig_p1 <= ambig_of(nxt_min, nxt_second);
    end else if (vld_p1 && out_ready) begin
      vld_p1   <= 1'b0;
    end
  end

  assign out_disp  = disp_p1;
  assign out_cost  = cost_p1;
  assign out_ambig = ambig_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_disparity_wta.sv
// Bench for disparity_wta: four DISP_RANGE=4 instances (margins 0..3) sharing stimulus,
// plus DISP_RANGE=1 and DISP_RANGE=64 instances for the extremes.
module tb_disparity_wta;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // group A: DISP_RANGE=4, UNIQ_MARGIN = instance index
  logic [9:0] a_in  = '0;
  logic       a_iv  = 1'b0;
  logic       a_or  = 1'b1;
  logic [1:0] a_disp   [4];
  logic [9:0] a_ocost  [4];
  logic       a_amb    [4];
  logic       a_ovalid [4];
  logic       a_iready [4];

  for (genvar g = 0; g < 4; g++) begin : g_a
    disparity_wta #(.COST_W(10), .DISP_RANGE(4), .UNIQ_MARGIN(g)) u_dut (
      .clk(clk), .rst(rst), .in_cost(a_in), .in_valid(a_iv), .in_ready(a_iready[g]),
      .out_disp(a_disp[g]), .out_cost(a_ocost[g]), .out_ambig(a_amb[g]),
      .out_valid(a_ovalid[g]), .out_ready(a_or));
  end

  // group B: DISP_RANGE=1
  logic [9:0] b_in = '0;
  logic       b_iv = 1'b0, b_or = 1'b1;
  logic [0:0] b_disp;
  logic [9:0] b_cost;
  logic       b_amb, b_ov, b_ir;
  disparity_wta #(.COST_W(10), .DISP_RANGE(1), .UNIQ_MARGIN(0)) u_b (
    .clk(clk), .rst(rst), .in_cost(b_in), .in_valid(b_iv), .in_ready(b_ir),
    .out_disp(b_disp), .out_cost(b_cost), .out_ambig(b_amb), .out_valid(b_ov),
    .out_ready(b_or));

  // group C: DISP_RANGE=64
  logic [9:0] c_in = '0;
  logic       c_iv = 1'b0, c_or = 1'b1;
  logic [5:0] c_disp;
  logic [9:0] c_cost;
  logic       c_amb, c_ov, c_ir;
  disparity_wta #(.COST_W(10), .DISP_RANGE(64), .UNIQ_MARGIN(0)) u_c (
    .clk(clk), .rst(rst), .in_cost(c_in), .in_valid(c_iv), .in_ready(c_ir),
    .out_disp(c_disp), .out_cost(c_cost), .out_ambig(c_amb), .out_valid(c_ov),
    .out_ready(c_or));

  typedef struct {
    int         disp;
    int         cost;
    logic [3:0] amb;   // bit m = expected out_ambig for UNIQ_MARGIN=m
  } res_t;

  typedef struct {
    int   c[4];
    res_t r;
  } vec_t;

  vec_t tbl[7];
  res_t exp_q[$];
  int   pix[$];
  int   n_res = 0;

  function automatic vec_t mk(input int c0, input int c1, input int c2, input int c3,
                              input int disp, input int cost, input logic [3:0] amb);
    vec_t v;
    v.c[0] = c0; v.c[1] = c1; v.c[2] = c2; v.c[3] = c3;
    v.r.disp = disp; v.r.cost = cost; v.r.amb = amb;
    return v;
  endfunction

  // Reference: winner is the first occurrence of the minimum, runner-up is the
  // second element of the sorted costs (saturated all-ones when there is none).
  function automatic res_t ref_pixel(input int c[$]);
    res_t r;
    int   s[$];
    int   sec;
    r.cost = c[0];
    r.disp = 0;
    for (int i = 1; i < c.size(); i++)
      if (c[i] < r.cost) begin r.cost = c[i]; r.disp = i; end
    s = c;
    s.sort();
    sec = (s.size() > 1) ? s[1] : 1023;
    for (int m = 0; m < 4; m++) r.amb[m] = (m != 0) && ((sec - r.cost) < m);
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_res(input string nm, input res_t e);
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("%s_disp_m%0d", nm, m), a_disp[m], e.disp);
      chk($sformatf("%s_cost_m%0d", nm, m), a_ocost[m], e.cost);
      chk($sformatf("%s_ambig_m%0d", nm, m), a_amb[m], int'(e.amb[m]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed_a(input int c);
    a_iv = 1'b1;
    a_in = 10'(c);
    step();
  endtask

  initial begin
    tbl[0] = mk(40, 12, 30, 25,  1,   12, 4'b0000);
    tbl[1] = mk( 9,  5,  5,  7,  1,    5, 4'b1110);
    tbl[2] = mk( 9,  5,  8,  7,  1,    5, 4'b1000);
    tbl[3] = mk( 3,  2,  1,  0,  3,    0, 4'b1100);
    tbl[4] = mk( 0,  0,  0,  0,  0,    0, 4'b1110);
    tbl[5] = mk(1023, 1023, 1023, 1023, 0, 1023, 4'b1110);
    tbl[6] = mk( 5,  4,  3,  4,  2,    3, 4'b1100);

    // reset state
    @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("rst_valid_m%0d", m), a_ovalid[m], 0);
      chk($sformatf("rst_disp_m%0d", m), a_disp[m], 0);
      chk($sformatf("rst_cost_m%0d", m), a_ocost[m], 0);
      chk($sformatf("rst_ready_m%0d", m), a_iready[m], 1);
    end
    step();
    rst = 1'b0;

    // table vectors streamed back-to-back: one result every 4 cycles, 1 cycle wide
    for (int i = 0; i < 7; i++) begin
      for (int b = 0; b < 4; b++) begin
        a_iv = 1'b1;
        a_in = 10'(tbl[i].c[b]);
        @(negedge clk);
        if (b == 0 && i > 0) chk_res($sformatf("vec%0d", i - 1), tbl[i - 1].r);
        chk($sformatf("vec%0d_b%0d_valid", i, b), a_ovalid[0], int'(b == 0 && i > 0));
        chk($sformatf("vec%0d_b%0d_inready", i, b), a_iready[0], 1);
        step();
      end
    end
    a_iv = 1'b0;
    @(negedge clk);
    chk_res("vec6", tbl[6].r);
    chk("vec6_valid", a_ovalid[0], 1);
    step();
    @(negedge clk);
    chk("vec6_valid_drop", a_ovalid[0], 0);
    step();

    // back-pressure: first result stalls, next pixel accumulates, last beat waits
    a_or = 1'b0;
    feed_a(40); feed_a(12); feed_a(30); feed_a(25);
    for (int b = 0; b < 3; b++) begin
      a_iv = 1'b1;
      a_in = 10'(3 - b);
      @(negedge clk);
      chk($sformatf("bp_b%0d_inready", b), a_iready[0], 1);
      chk($sformatf("bp_b%0d_valid", b), a_ovalid[0], 1);
      chk($sformatf("bp_b%0d_disp", b), a_disp[0], 1);
      chk($sformatf("bp_b%0d_cost", b), a_ocost[0], 12);
      step();
    end
    a_in = 10'd0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("bp_stall%0d_inready", k), a_iready[0], 0);
      chk($sformatf("bp_stall%0d_disp", k), a_disp[0], 1);
      chk($sformatf("bp_stall%0d_cost", k), a_ocost[0], 12);
      chk($sformatf("bp_stall%0d_valid", k), a_ovalid[0], 1);
      step();
    end
    a_or = 1'b1;
    @(negedge clk);
    chk("bp_release_inready", a_iready[0], 1);
    chk("bp_release_old_disp", a_disp[0], 1);
    step();
    a_iv = 1'b0;
    @(negedge clk);
    chk("bp_new_valid", a_ovalid[0], 1);
    chk("bp_new_disp", a_disp[0], 3);
    chk("bp_new_cost", a_ocost[0], 0);
    step();
    @(negedge clk);
    chk("bp_new_valid_drop", a_ovalid[0], 0);
    step();

    // asynchronous reset mid-pixel with a stalled result pending
    a_or = 1'b0;
    feed_a(40); feed_a(12); feed_a(30); feed_a(25);
    feed_a(50); feed_a(60); feed_a(70);
    a_iv = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", a_ovalid[0], 0);
    chk("mid_rst_disp", a_disp[0], 0);
    chk("mid_rst_cost", a_ocost[0], 0);
    chk("mid_rst_inready", a_iready[0], 1);
    step();
    rst = 1'b0;
    a_or = 1'b1;
    feed_a(6); feed_a(7); feed_a(8); feed_a(1);
    a_iv = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", a_ovalid[0], 1);
    begin
      res_t e;
      e.disp = 3; e.cost = 1; e.amb = 4'b0000;
      chk_res("post_rst", e);
    end
    step();

    // randomized traffic against the reference model
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int cyc = 0; cyc < 700; cyc++) begin
      bit drain;
      bit exp_ir;
      drain = (cyc >= 690);
      a_iv = drain ? 1'b0 : ($urandom_range(0, 9) < 7);
      a_in = $urandom_range(0, 1) ? 10'($urandom_range(0, 7)) : 10'($urandom_range(0, 1023));
      a_or = drain ? 1'b1 : ($urandom_range(0, 9) < 6);
      @(negedge clk);
      exp_ir = !(exp_q.size() != 0 && !a_or && pix.size() == 3);
      chk($sformatf("rnd%0d_valid", cyc), a_ovalid[0], int'(exp_q.size() != 0));
      chk($sformatf("rnd%0d_inready", cyc), a_iready[0], int'(exp_ir));
      if (exp_q.size() != 0 && a_or) begin
        chk_res($sformatf("rnd%0d", cyc), exp_q.pop_front());
        n_res++;
      end
      if (a_iv && exp_ir) begin
        pix.push_back(int'(a_in));
        if (pix.size() == 4) begin
          exp_q.push_back(ref_pixel(pix));
          pix.delete();
        end
      end
      step();
    end
    chk("rnd_drained", exp_q.size(), 0);
    chk("rnd_enough_results", int'(n_res >= 40), 1);

    // DISP_RANGE=1: every beat is a complete pixel
    b_or = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (k % 2 == 0) ? 1023 : 17 * k;
      b_iv = 1'b1;
      b_in = 10'(c);
      step();
      @(negedge clk);
      chk($sformatf("dr1_k%0d_valid", k), b_ov, 1);
      chk($sformatf("dr1_k%0d_disp", k), b_disp, 0);
      chk($sformatf("dr1_k%0d_cost", k), b_cost, c);
      chk($sformatf("dr1_k%0d_ambig", k), b_amb, 0);
    end
    b_iv = 1'b0;
    b_or = 1'b0;
    #1;
    chk("dr1_stall_inready", b_ir, 0);
    step();

    // DISP_RANGE=64: only the last disparity is cheaper; then an all-tie pixel
    c_or = 1'b1;
    for (int p = 0; p < 2; p++) begin
      for (int d = 0; d < 64; d++) begin
        c_iv = 1'b1;
        c_in = (p == 0 && d == 63) ? 10'd1022 : 10'd1023;
        @(negedge clk);
        if (d == 0) chk($sformatf("dr64_p%0d_inready", p), c_ir, 1);
        step();
      end
      c_iv = 1'b0;
      @(negedge clk);
      chk($sformatf("dr64_p%0d_valid", p), c_ov, 1);
      chk($sformatf("dr64_p%0d_disp", p), c_disp, (p == 0) ? 63 : 0);
      chk($sformatf("dr64_p%0d_cost", p), c_cost, (p == 0) ? 1022 : 1023);
      chk($sformatf("dr64_p%0d_ambig", p), c_amb, 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
